// File: rtl/icache_refill_unit_pkg.sv
// Shared constants, the block alignment helper and the refill FSM state type
// for the L1 instruction-cache refill engine.
package icache_refill_unit_pkg;

    localparam int SIZE_PC     = 32;
    localparam int CACHE_WIDTH = 256;
    localparam int MEM_WIDTH   = 64;
    localparam int BEATS       = CACHE_WIDTH / MEM_WIDTH;
    localparam int BEAT_CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    // Byte-offset bits inside one cache block
    localparam logic [SIZE_PC-1:0] BLK_OFFSET_MASK = SIZE_PC'(CACHE_WIDTH / 8 - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FILL  = 2'd2,
        ST_WRITE = 2'd3
    } refill_state_e;

    // Drop the byte offset so the address names the whole block
    function automatic logic [SIZE_PC-1:0] blk_align(input logic [SIZE_PC-1:0] addr);
        return addr & ~BLK_OFFSET_MASK;
    endfunction

endpackage

// File: rtl/icache_refill_unit_if.sv
// Signal bundle between the refill unit, the fetch stage, lower memory and the
// cache fill port. Names are from the refill unit's point of view.
interface icache_refill_unit_if;
    import icache_refill_unit_pkg::*;

    logic                   miss_i;
    logic [SIZE_PC-1:0]     missAddr_i;
    logic                   memReqValid_o;
    logic                   memReqReady_i;
    logic [SIZE_PC-1:0]     memReqAddr_o;
    logic                   memRspValid_i;
    logic [MEM_WIDTH-1:0]   memRspData_i;
    logic                   wrEnable_o;
    logic [SIZE_PC-1:0]     wrAddr_o;
    logic [CACHE_WIDTH-1:0] instBlock_o;
    logic                   busy_o;
    logic                   protoErr_o;

    // Refill unit side: it masters the memory read and the cache fill
    modport master (
        input  miss_i, missAddr_i, memReqReady_i, memRspValid_i, memRspData_i,
        output memReqValid_o, memReqAddr_o, wrEnable_o, wrAddr_o, instBlock_o,
        busy_o, protoErr_o
    );

    // Environment side: fetch stage, memory and cache
    modport slave (
        output miss_i, missAddr_i, memReqReady_i, memRspValid_i, memRspData_i,
        input  memReqValid_o, memReqAddr_o, wrEnable_o, wrAddr_o, instBlock_o,
        busy_o, protoErr_o
    );

endinterface

// File: rtl/icache_refill_unit_refill_beat_assembler.sv
// Collects MEM_WIDTH response beats into one CACHE_WIDTH block. Beat 0 lands
// in the least significant slice; the counter wraps once the block is full.
module refill_beat_assembler
    import icache_refill_unit_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   beatValid,
    input  logic [MEM_WIDTH-1:0]   beatData,
    output logic                   done,
    output logic [CACHE_WIDTH-1:0] block
);

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);

    logic [BEAT_CNT_W-1:0]  r_beat_cnt;
    logic [CACHE_WIDTH-1:0] r_block;
    logic [BEATS-1:0]       w_slice_we;

    // One write enable per block slice, selected by the beat counter
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice_we
        assign w_slice_we[gi] = beatValid && (r_beat_cnt == BEAT_CNT_W'(gi));
    end

    // Beat counter: cleared at the request handshake, wraps after the last beat
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_beat_cnt <= '0;
        end else if (beatValid) begin
            r_beat_cnt <= (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + BEAT_CNT_W'(1);
        end
    end

    // Block register: each beat overwrites only its own slice
    always_ff @(posedge clk) begin
        if (reset) begin
            r_block <= '0;
        end else begin
            for (int i = 0; i < BEATS; i++) begin
                if (w_slice_we[i]) begin
                    r_block[i*MEM_WIDTH +: MEM_WIDTH] <= beatData;
                end
            end
        end
    end

    assign done  = beatValid && (r_beat_cnt == LAST_BEAT);
    assign block = r_block;

endmodule

// File: rtl/icache_refill_unit.sv
// L1 instruction-cache miss engine: takes one miss, issues a block-aligned
// read, assembles BEATS response beats and pulses a single fill write.
module icache_refill_unit
    import icache_refill_unit_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    icache_refill_unit_if.master bus
);

    refill_state_e          r_state;
    refill_state_e          w_state_next;
    logic [SIZE_PC-1:0]     r_blk_addr;
    logic [SIZE_PC-1:0]     r_last_addr;
    logic                   r_just_wrote;
    logic                   r_proto_err;

    logic [SIZE_PC-1:0]     w_blk_addr_in;
    logic                   w_miss_accept;
    logic                   w_req_fire;
    logic                   w_beat_valid;
    logic                   w_block_done;
    logic [CACHE_WIDTH-1:0] w_block;

    assign w_blk_addr_in = blk_align(bus.missAddr_i);
    // A miss still pointing at the block written last cycle is stale, not new
    assign w_miss_accept = bus.miss_i && !(r_just_wrote && (w_blk_addr_in == r_last_addr));
    assign w_req_fire    = (r_state == ST_REQ) && bus.memReqReady_i;
    assign w_beat_valid  = (r_state == ST_FILL) && bus.memRspValid_i;

    refill_beat_assembler u_assembler (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_req_fire),
        .beatValid (w_beat_valid),
        .beatData  (bus.memRspData_i),
        .done      (w_block_done),
        .block     (w_block)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_miss_accept)      w_state_next = ST_REQ;
            ST_REQ:   if (bus.memReqReady_i)  w_state_next = ST_FILL;
            ST_FILL:  if (w_block_done)       w_state_next = ST_WRITE;
            ST_WRITE:                         w_state_next = ST_IDLE;
            default:                          w_state_next = ST_IDLE;
        endcase
    end

    // Block address captured once per miss; later miss changes are ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blk_addr <= '0;
        end else if ((r_state == ST_IDLE) && w_miss_accept) begin
            r_blk_addr <= w_blk_addr_in;
        end
    end

    // Remember the block just filled for one IDLE cycle to mask a stale miss
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_addr  <= '0;
            r_just_wrote <= 1'b0;
        end else if (r_state == ST_WRITE) begin
            r_last_addr  <= r_blk_addr;
            r_just_wrote <= 1'b1;
        end else if (r_state == ST_IDLE) begin
            r_just_wrote <= 1'b0;
        end
    end

    // Sticky flag for response beats arriving when no fill is in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            r_proto_err <= 1'b0;
        end else if (bus.memRspValid_i && (r_state != ST_FILL)) begin
            r_proto_err <= 1'b1;
        end
    end

    assign bus.memReqValid_o = (r_state == ST_REQ);
    assign bus.memReqAddr_o  = r_blk_addr;
    assign bus.wrEnable_o    = (r_state == ST_WRITE);
    assign bus.wrAddr_o      = r_blk_addr;
    assign bus.instBlock_o   = w_block;
    assign bus.busy_o        = (r_state != ST_IDLE);
    assign bus.protoErr_o    = r_proto_err;

endmodule

// File: doc/icache_refill_unit.md
# icache_refill_unit

Miss-handling engine on the memory side of the L1 instruction cache. It accepts the fetch stage's `miss_o`/`missAddr_o` pair and fetches the missing block from lower memory as a sequence of narrow beats. It assembles the beats into one `CACHE_WIDTH` block and returns it to the cache on the `wrEnable_i`/`wrAddr_i`/`instBlock_i` fill port. One miss is outstanding at a time.

## Interface
Parameters:
- `SIZE_PC`, 32, address width (matches `` `SIZE_PC``)
- `CACHE_WIDTH`, 256, cache block width in bits (matches `` `CACHE_WIDTH``)
- `MEM_WIDTH`, 64, width of one memory response beat; `CACHE_WIDTH` must be an integer multiple of it
- `BEATS`, `CACHE_WIDTH/MEM_WIDTH` (4), beats per block

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `miss_i`  in  1  cache miss from fetch; held high until the fill lands
- `missAddr_i`  in  `SIZE_PC`  miss address (any byte within the block)
- `memReqValid_o`  out  1  read request valid
- `memReqReady_i`  in  1  memory accepts the request
- `memReqAddr_o`  out  `SIZE_PC`  block-aligned request address
- `memRspValid_i`  in  1  response beat valid (no backpressure)
- `memRspData_i`  in  `MEM_WIDTH`  response beat data
- `wrEnable_o`  out  1  one-cycle fill strobe to the cache
- `wrAddr_o`  out  `SIZE_PC`  block-aligned fill address
- `instBlock_o`  out  `CACHE_WIDTH`  assembled block
- `busy_o`  out  1  high in every state except IDLE
- `protoErr_o`  out  1  sticky flag: a response beat arrived outside FILL

## Operation
- FSM states: IDLE, REQ, FILL, WRITE. All outputs are registered or decoded from the state register.
- **IDLE**
  - On `miss_i` = 1, latch `blkAddr = missAddr_i & ~(CACHE_WIDTH/8-1)` and go to REQ.
  - Exception: the miss is ignored if `blkAddr` equals `lastAddr` and `justWrote` = 1.
  - `justWrote` is set in WRITE and cleared after the first IDLE cycle. This keeps a stale miss for the block just filled from retriggering a fetch.
- **REQ**
  - `memReqValid_o` = 1 and `memReqAddr_o` = `blkAddr`, both held stable until `memReqReady_i` = 1.
  - On the handshake, clear `beatCnt` and go to FILL.
- **FILL**
  - Each cycle with `memRspValid_i` = 1, write `memRspData_i` into slice `[beatCnt*MEM_WIDTH +: MEM_WIDTH]` of the block register and increment `beatCnt`.
  - Beat 0 is the lowest-addressed word.
  - After beat `BEATS-1` is captured, go to WRITE.
- **WRITE**
  - `wrEnable_o` = 1 for exactly one cycle, with `wrAddr_o` = `blkAddr` and `instBlock_o` = the full block.
  - Set `lastAddr` = `blkAddr` and `justWrote` = 1, then go to IDLE.
- A `memRspValid_i` beat in IDLE, REQ or WRITE is dropped and sets `protoErr_o`. Only `reset` clears `protoErr_o`.
- Changes to `miss_i`/`missAddr_i` after IDLE are ignored. A fetch redirect or flush does not abort the fill; the block is still correct for its address and is written.
- Arithmetic:
  - `beatCnt` is `$clog2(BEATS)` bits and wraps to 0 when the block completes.
  - No address arithmetic beyond the alignment mask.

## Timing
- Reset values:
  - state = IDLE; `justWrote` = 0
  - `memReqValid_o` = 0, `wrEnable_o` = 0, `busy_o` = 0, `protoErr_o` = 0
  - `memReqAddr_o` = 0, `wrAddr_o` = 0, `instBlock_o` = 0, `lastAddr` = 0
- Reset asserted mid-operation returns to IDLE on the next edge. The partial block is discarded and no `wrEnable_o` is issued.
- `miss_i` sampled at edge N puts `memReqValid_o` high during cycle N+1.
- `memRspValid_i` may be high in the first cycle after the request handshake.
- `wrEnable_o` is high in the cycle after the last beat is captured.
- Minimum latency from miss to `wrEnable_o` with a single-cycle handshake and back-to-back beats: `BEATS` + 2 cycles.
- The earliest new miss is accepted in the first IDLE cycle after WRITE, subject to the `justWrote` guard.

## Structure
- Shared package: `SIZE_PC`, `CACHE_WIDTH`, `MEM_WIDTH`, `BEATS`, the block-offset mask, and the refill FSM state enum.
- Natural sub-module: `refill_beat_assembler`, containing the beat counter and block shift/insert register, with `clear`, `beatValid`, `beatData`, `done` and `block` ports.

## Test plan
- **Basic fill:** reset, then `miss_i`=1 with `missAddr_i`=0x1234 → `memReqAddr_o`=0x1220; `memReqReady_i` immediate; four beats 0xA..0xD → one `wrEnable_o` pulse, `wrAddr_o`=0x1220, `instBlock_o`={0xD,0xC,0xB,0xA}.
- **Request backpressure:** hold `memReqReady_i`=0 for 5 cycles → `memReqValid_o` and `memReqAddr_o` stable throughout; no beats accepted before the handshake.
- **Gapped beats:** beats separated by 0–3 idle cycles → same block as back-to-back delivery; `busy_o`=1 until WRITE completes.
- **Stale miss guard:** hold `miss_i`=1 on 0x1234 one cycle past WRITE → no second request. Miss to 0x2000 in that same cycle → request to 0x2000.
- **Stray beat:** `memRspValid_i`=1 while IDLE → data dropped, `protoErr_o`=1 and it stays high until reset.
- **Reset mid-FILL:** reset after 2 of 4 beats → IDLE next cycle, no `wrEnable_o`; a new miss then completes a normal fill.
